// File: rtl/halflife_decay_timer_pkg.sv
// Shared types and helpers for the half-life decay timer: state encoding,
// command priority ordering and saturating add/sub helpers.
package halflife_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DECAY = 2'd1,
        DONE  = 2'd2
    } hl_state_t;

    // Commands listed from highest to lowest priority; CMD_NONE means
    // nothing was asserted this cycle.
    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_LOAD  = 3'd1,
        CMD_STOP  = 3'd2,
        CMD_START = 3'd3,
        CMD_UP    = 3'd4,
        CMD_DOWN  = 3'd5
    } hl_cmd_t;

    // Widest count the helpers below can handle.
    localparam int HL_MAX_W = 32;

    // Only the highest-priority asserted command survives.
    function automatic hl_cmd_t pick_cmd(input logic load, input logic stop,
                                         input logic start, input logic up,
                                         input logic down);
        if (load)  return CMD_LOAD;
        if (stop)  return CMD_STOP;
        if (start) return CMD_START;
        if (up)    return CMD_UP;
        if (down)  return CMD_DOWN;
        return CMD_NONE;
    endfunction

    // a + b clamped to 2^w - 1; operands are zero-extended w-bit values,
    // the one extra bit of headroom catches the carry out.
    function automatic logic [HL_MAX_W-1:0] sat_add(input logic [HL_MAX_W-1:0] a,
                                                    input logic [HL_MAX_W-1:0] b,
                                                    input int w);
        logic [HL_MAX_W:0] sum;
        logic [HL_MAX_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((HL_MAX_W+1)'(1) << w) - (HL_MAX_W+1)'(1);
        return (sum > lim) ? lim[HL_MAX_W-1:0] : sum[HL_MAX_W-1:0];
    endfunction

    // a - b clamped at zero.
    function automatic logic [HL_MAX_W-1:0] sat_sub(input logic [HL_MAX_W-1:0] a,
                                                    input logic [HL_MAX_W-1:0] b);
        return (a < b) ? '0 : (a - b);
    endfunction

endpackage

// File: rtl/halflife_decay_timer_if.sv
// Command/status bundle between the controlling logic and the decay timer.
interface halflife_decay_timer_if #(
    parameter int WIDTH  = 8,
    parameter int PER_W  = 16,
    parameter int HCNT_W = 4
);
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic              up;
    logic              down;
    logic [WIDTH-1:0]  step;
    logic              start;
    logic              stop;
    logic [PER_W-1:0]  period;
    logic [WIDTH-1:0]  count;
    logic              busy;
    logic              done;
    logic [HCNT_W-1:0] halvings;

    modport master (
        output load, load_val, up, down, step, start, stop, period,
        input  count, busy, done, halvings
    );

    modport slave (
        input  load, load_val, up, down, step, start, stop, period,
        output count, busy, done, halvings
    );
endinterface

// File: rtl/halflife_decay_timer_prescaler.sv
// Half-life prescaler: counts cycles while enabled and raises tick on the
// cycle whose edge should perform a halving. A period of 0 behaves as 1.
module halflife_prescaler #(
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [PER_W-1:0] period,
    output logic             tick
);

    logic [PER_W-1:0] pre_q;
    logic [PER_W-1:0] last;

    // Terminal count; >= rather than == so that shrinking the period below
    // the current count fires on the very next edge instead of wrapping.
    always_comb begin
        last = (period == '0) ? '0 : period - PER_W'(1);
        tick = en && (pre_q >= last);
    end

    // Cycle counter, restarted by clr and on every tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
        end else if (clr || tick) begin
            pre_q <= '0;
        end else if (en) begin
            pre_q <= pre_q + PER_W'(1);
        end
    end

endmodule

// File: rtl/halflife_decay_timer.sv
// Half-life decay timer: saturating up/down/load counter that, once started,
// halves itself every `period` cycles until zero, then pulses done.
// HCNT_W must satisfy 2^HCNT_W > WIDTH so a full decay is countable.
module halflife_decay_timer
    import halflife_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int PER_W  = 16,
    parameter int HCNT_W = 4
) (
    input logic                   clk,
    input logic                   rst,
    halflife_decay_timer_if.slave io
);

    hl_state_t         state_q, state_n;
    hl_cmd_t           cmd;
    logic [WIDTH-1:0]  cnt_q, cnt_n;
    logic [HCNT_W-1:0] halv_q, halv_n;
    logic              busy_q, done_q, done_n;
    logic              pre_clr;
    logic              tick;

    halflife_prescaler #(
        .PER_W (PER_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clr    (pre_clr),
        .en     (state_q == DECAY),
        .period (io.period),
        .tick   (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state and datapath values; one command acts per cycle.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        halv_n  = halv_q;
        done_n  = 1'b0;
        pre_clr = 1'b0;
        cmd     = pick_cmd(io.load, io.stop, io.start, io.up, io.down);
        case (state_q)
            DECAY: begin
                case (cmd)
                    CMD_LOAD: begin
                        cnt_n   = io.load_val;
                        state_n = IDLE;
                    end
                    CMD_STOP: state_n = IDLE;
                    default: begin
                        // start/up/down are ignored while decaying
                        if (tick) begin
                            cnt_n  = cnt_q >> 1;
                            halv_n = (halv_q == '1) ? halv_q : halv_q + HCNT_W'(1);
                            if (cnt_n == '0) begin
                                state_n = DONE;
                                done_n  = 1'b1;
                            end
                        end
                    end
                endcase
            end
            default: begin
                case (cmd)
                    CMD_LOAD: begin
                        cnt_n   = io.load_val;
                        state_n = IDLE;
                    end
                    CMD_START: begin
                        halv_n  = '0;
                        pre_clr = 1'b1;
                        if (cnt_q != '0) begin
                            state_n = DECAY;
                        end else begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end
                    end
                    CMD_UP: begin
                        cnt_n   = WIDTH'(sat_add(HL_MAX_W'(cnt_q), HL_MAX_W'(io.step), WIDTH));
                        state_n = IDLE;
                    end
                    CMD_DOWN: begin
                        cnt_n   = WIDTH'(sat_sub(HL_MAX_W'(cnt_q), HL_MAX_W'(io.step)));
                        state_n = IDLE;
                    end
                    default: ;
                endcase
            end
        endcase
    end

    // Registered count, halvings and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            halv_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_n;
            halv_q <= halv_n;
            busy_q <= (state_n == DECAY);
            done_q <= done_n;
        end
    end

    assign io.count    = cnt_q;
    assign io.halvings = halv_q;
    assign io.busy     = busy_q;
    assign io.done     = done_q;

endmodule

// File: tb/tb_halflife_decay_timer.sv
// Directed bench for halflife_decay_timer: a vector table for single-cycle
// commands plus hand-written multi-cycle decay sequences.
module tb_halflife_decay_timer;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    halflife_decay_timer_if #(.WIDTH(8), .PER_W(16), .HCNT_W(4)) hif ();

    halflife_decay_timer #(
        .WIDTH  (8),
        .PER_W  (16),
        .HCNT_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic [7:0]  lv;
        logic        up;
        logic        dn;
        logic [7:0]  st;
        logic        sa;
        logic        sp;
        logic [15:0] per;
        logic [7:0]  e_cnt;
        logic        e_busy;
        logic        e_done;
        logic [3:0]  e_halv;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input int ld, input int lv, input int up, input int dn,
                                input int st, input int sa, input int sp, input int per,
                                input int ec, input int eb, input int ed, input int eh);
        vec_t v;
        v.ld = 1'(ld);   v.lv = 8'(lv);  v.up = 1'(up);   v.dn = 1'(dn);
        v.st = 8'(st);   v.sa = 1'(sa);  v.sp = 1'(sp);   v.per = 16'(per);
        v.e_cnt = 8'(ec); v.e_busy = 1'(eb); v.e_done = 1'(ed); v.e_halv = 4'(eh);
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string nm, input int ec, input int eb, input int ed, input int eh);
        check({nm, ".count"},    32'(hif.count),    32'(ec));
        check({nm, ".busy"},     32'(hif.busy),     32'(eb));
        check({nm, ".done"},     32'(hif.done),     32'(ed));
        check({nm, ".halvings"}, 32'(hif.halvings), 32'(eh));
    endtask

    task automatic tick_clk;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cmds;
        hif.load  = 1'b0;
        hif.up    = 1'b0;
        hif.down  = 1'b0;
        hif.start = 1'b0;
        hif.stop  = 1'b0;
    endtask

    // One-cycle load of a value.
    task automatic do_load(input logic [7:0] v);
        hif.load_val = v;
        hif.load     = 1'b1;
        tick_clk();
        clr_cmds();
    endtask

    // One-cycle start with the given period.
    task automatic do_start(input logic [15:0] p);
        hif.period = p;
        hif.start  = 1'b1;
        tick_clk();
        clr_cmds();
    endtask

    logic [7:0] dexp[8];
    logic [7:0] pexp[8];
    int         dpulses;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        clr_cmds();
        hif.load_val = 8'h00;
        hif.step     = 8'h00;
        hif.period   = 16'd1;
        rst          = 1'b0;

        // vector table: inputs for one edge, outputs expected after it
        tbl[0]  = mk(1, 'hF0, 0, 0, 'h00, 0, 0, 1, 'hF0, 0, 0, 0);
        tbl[1]  = mk(0, 'h00, 1, 0, 'h20, 0, 0, 1, 'hFF, 0, 0, 0);
        tbl[2]  = mk(1, 'h10, 0, 0, 'h00, 0, 0, 1, 'h10, 0, 0, 0);
        tbl[3]  = mk(0, 'h00, 0, 1, 'h30, 0, 0, 1, 'h00, 0, 0, 0);
        tbl[4]  = mk(1, 'h55, 1, 0, 'h01, 0, 0, 1, 'h55, 0, 0, 0);
        tbl[5]  = mk(0, 'h00, 1, 0, 'h0A, 0, 0, 1, 'h5F, 0, 0, 0);
        tbl[6]  = mk(0, 'h00, 0, 1, 'h0F, 0, 0, 1, 'h50, 0, 0, 0);
        tbl[7]  = mk(0, 'h00, 1, 1, 'h04, 0, 0, 1, 'h54, 0, 0, 0);
        tbl[8]  = mk(0, 'h00, 0, 0, 'h00, 0, 1, 1, 'h54, 0, 0, 0);
        tbl[9]  = mk(0, 'h00, 1, 0, 'h01, 0, 1, 1, 'h54, 0, 0, 0);
        tbl[10] = mk(0, 'h00, 0, 1, 'h54, 0, 0, 1, 'h00, 0, 0, 0);
        tbl[11] = mk(0, 'h00, 0, 0, 'h00, 1, 0, 1, 'h00, 0, 1, 0);
        tbl[12] = mk(0, 'h00, 0, 0, 'h00, 0, 0, 1, 'h00, 0, 0, 0);
        tbl[13] = mk(0, 'h00, 1, 0, 'h03, 0, 0, 1, 'h03, 0, 0, 0);
        tbl[14] = mk(0, 'h00, 0, 0, 'h00, 1, 0, 1, 'h03, 1, 0, 0);
        tbl[15] = mk(0, 'h00, 0, 0, 'h00, 0, 0, 1, 'h01, 1, 0, 1);
        tbl[16] = mk(0, 'h00, 1, 0, 'h05, 0, 0, 1, 'h00, 0, 1, 2);
        tbl[17] = mk(0, 'h00, 0, 0, 'h00, 0, 0, 1, 'h00, 0, 0, 2);
        tbl[18] = mk(0, 'h00, 0, 1, 'h01, 0, 0, 1, 'h00, 0, 0, 2);
        tbl[19] = mk(1, 'h07, 0, 0, 'h00, 0, 0, 0, 'h07, 0, 0, 2);

        dexp = '{8'd90, 8'd45, 8'd22, 8'd11, 8'd5, 8'd2, 8'd1, 8'd0};
        pexp = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

        // reset state
        repeat (2) tick_clk();
        check_out("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        tick_clk();
        check_out("post_reset", 0, 0, 0, 0);

        // table-driven single-cycle commands
        for (int i = 0; i < 20; i++) begin
            hif.load     = tbl[i].ld;
            hif.load_val = tbl[i].lv;
            hif.up       = tbl[i].up;
            hif.down     = tbl[i].dn;
            hif.step     = tbl[i].st;
            hif.start    = tbl[i].sa;
            hif.stop     = tbl[i].sp;
            hif.period   = tbl[i].per;
            tick_clk();
            clr_cmds();
            check_out($sformatf("vec%0d", i), int'(tbl[i].e_cnt), int'(tbl[i].e_busy),
                      int'(tbl[i].e_done), int'(tbl[i].e_halv));
        end

        // full decay of 180 with period 3
        do_load(8'hB4);
        do_start(16'd3);
        check_out("d180_start", 'hB4, 1, 0, 0);
        dpulses = 0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 2; j++) begin
                tick_clk();
                dpulses += int'(hif.done);
                check($sformatf("d180_hold%0d_%0d", i, j), 32'(hif.count),
                      (i == 0) ? 32'hB4 : 32'(dexp[i-1]));
            end
            tick_clk();
            dpulses += int'(hif.done);
            check_out($sformatf("d180_h%0d", i), int'(dexp[i]), (i == 7) ? 0 : 1,
                      (i == 7) ? 1 : 0, i + 1);
        end
        repeat (3) begin
            tick_clk();
            dpulses += int'(hif.done);
        end
        check("d180_done_pulses", 32'(dpulses), 32'd1);
        check_out("d180_after", 0, 0, 0, 8);

        // stop after the second halving, then restart
        do_load(8'h40);
        do_start(16'd4);
        repeat (8) tick_clk();
        check_out("abort_pre", 'h10, 1, 0, 2);
        hif.stop = 1'b1;
        tick_clk();
        clr_cmds();
        check_out("abort_stop", 'h10, 0, 0, 2);
        repeat (5) tick_clk();
        check_out("abort_hold", 'h10, 0, 0, 2);
        do_start(16'd4);
        check_out("restart", 'h10, 1, 0, 0);
        repeat (3) tick_clk();

        // asynchronous reset mid-decay
        #2;
        rst = 1'b0;
        #1;
        check_out("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        tick_clk();
        check_out("async_rst_rel", 0, 0, 0, 0);

        // start from zero
        do_start(16'd5);
        check_out("zero_start", 0, 0, 1, 0);
        tick_clk();
        check_out("zero_start_after", 0, 0, 0, 0);

        // period 0 behaves as 1
        do_load(8'h80);
        do_start(16'd0);
        check_out("p0_start", 'h80, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick_clk();
            check_out($sformatf("p0_h%0d", i), int'(pexp[i]), (i == 7) ? 0 : 1,
                      (i == 7) ? 1 : 0, i + 1);
        end

        // period shrinks below the running prescaler
        do_load(8'hFF);
        do_start(16'd10);
        repeat (6) tick_clk();
        check_out("pchg_pre", 'hFF, 1, 0, 0);
        hif.period = 16'd4;
        tick_clk();
        check_out("pchg_fire", 'h7F, 1, 0, 1);
        hif.up   = 1'b1;
        hif.step = 8'h01;
        tick_clk();
        hif.up   = 1'b0;
        hif.down = 1'b1;
        tick_clk();
        clr_cmds();
        tick_clk();
        check_out("pchg_ignored", 'h7F, 1, 0, 1);
        tick_clk();
        check_out("pchg_next", 'h3F, 1, 0, 2);
        hif.stop = 1'b1;
        tick_clk();
        clr_cmds();
        check_out("pchg_stop", 'h3F, 0, 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/halflife_decay_timer.md
# halflife_decay_timer

Parametrised half-life timer with a saturating up/down/load counter and an autonomous decay mode. In decay mode the count halves (logical shift right by one) every `period` cycles until it reaches zero. A single-cycle `done` pulse then fires, and `halvings` reports how many half-lives elapsed. It sits beside the existing half-life counter datapath as its next-generation replacement, driven by the same control logic, with generalised width and a programmable decay rate.

## Interface
- `WIDTH`, 8, width of count, load value and step
- `PER_W`, 16, width of the prescaler / `period` input
- `HCNT_W`, 4, width of the halvings counter; must satisfy 2^HCNT_W > WIDTH
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous reset, active-low
- `load`  in  1  load `load_val` into count
- `load_val`  in  WIDTH  value to load
- `up`  in  1  add `step` to count, saturating
- `down`  in  1  subtract `step` from count, saturating
- `step`  in  WIDTH  increment/decrement amount
- `start`  in  1  enter decay mode
- `stop`  in  1  abort decay, hold count
- `period`  in  PER_W  cycles per half-life; 0 is treated as 1
- `count`  out  WIDTH  current value, registered
- `busy`  out  1  high in DECAY
- `done`  out  1  one-cycle pulse when decay reaches zero
- `halvings`  out  HCNT_W  halvings since the last `start`

## Operation
- States are IDLE, DECAY and DONE; the state register is encoded per the package enum.
- Reset (rst=0, asynchronous):
  - state=IDLE
  - count=0, halvings=0, busy=0, done=0
  - prescaler=0
- Command priority each cycle: `load` > `stop` > `start` > `up` > `down`. Only the highest-priority asserted command acts.
- `load` is legal in any state.
  - It sets count=load_val and moves to IDLE, aborting any decay.
  - halvings is unchanged.
- `stop` in DECAY moves to IDLE and holds count and halvings. In IDLE and DONE it has no effect.
- `start` in IDLE or DONE:
  - clears halvings and the prescaler.
  - If count≠0, it moves to DECAY.
  - If count==0, it moves to DONE with `done` pulsed.
  - In DECAY, `start` is ignored; it does not restart.
- `up`/`down` act only in IDLE or DONE and are ignored in DECAY.
  - Arithmetic is WIDTH+1 bits wide.
  - `up` gives count = min(count+step, 2^WIDTH−1).
  - `down` gives count = max(count−step, 0).
  - Either one in DONE moves to IDLE.
- DECAY:
  - The prescaler increments each cycle.
  - When prescaler == max(period,1)−1:
    - prescaler returns to 0
    - count becomes count>>1
    - halvings increments, saturating at 2^HCNT_W−1
  - If the new count is 0, the state becomes DONE and `done`=1 for exactly that cycle's registered output.
- DONE holds count=0 until `load`, `start`, `up` or `down`.
- A change of `period` during DECAY takes effect on the next compare. If the new period is ≤ the current prescaler value, the halving fires on the next cycle and the prescaler resets.

## Timing
- All outputs are registered. There is no combinational input→output path.
- `load`, `up`, `down` and `stop` are visible on `count`/`busy` one cycle after the sampling edge.
- `start` asserted at edge k makes `busy`=1 after edge k.
- The first halving appears after edge k+max(period,1). Later halvings follow every max(period,1) cycles.
- Decay from value V≠0 takes floor(log2 V)+1 halvings. The `done` pulse is coincident with count becoming 0 and busy falling.
- Asynchronous reset mid-DECAY clears everything immediately. Deassertion is synchronised externally.

## Structure
- Package `halflife_pkg` holds:
  - the state enum `hl_state_t` {IDLE, DECAY, DONE}
  - the command-priority constants
  - saturating add/sub functions parametrised by WIDTH
- One natural sub-module is `halflife_prescaler`. It covers the PER_W counter with clear, period compare (0→1 mapping) and a one-cycle `tick` output.
- The FSM and the datapath stay in `halflife_decay_timer`.

## Test plan
- Reset, then load 0xB4 (180), start with period=3:
  - count steps 90, 45, 22, 11, 5, 2, 1, 0 every 3 cycles.
  - `done` pulses once.
  - halvings=8.
  - busy falls with the done pulse.
- Saturation:
  - load 0xF0, up with step=0x20 → 0xFF
  - load 0x10, down with step=0x30 → 0x00
  - load with up simultaneously → load value wins
- Abort and reset:
  - Start from 0x40 with period=4; stop after the 2nd halving → count=0x10, halvings=2, IDLE.
  - Restart → halvings clears to 0.
  - rst low mid-decay → all outputs 0 immediately.
- Edge cases:
  - start with count=0 → `done` pulse one cycle later, halvings=0.
  - period=0 with load 0x80 → halves every cycle, done after 8 cycles.
- Mid-decay period change:
  - period=10 and prescaler at 6, then period changed to 4 → halving on the next cycle.
  - The following halving comes 4 cycles later.
  - up/down pulses in DECAY → ignored.
